enemy_hp: RTL and testbench
===========================

# enemy_hp

Enemy hit-point tracker that sits directly downstream of the attack-bar stage. It consumes the `spacePressed`/`damage` pair produced during the attack state (`state==2`) and applies exactly one saturating hit per attack turn. It runs the hit-flash and turn-end timing, and renders the enemy HP bar pixels for the VGA mixer. It signals the game FSM when the attack turn is finished and when the enemy is dead.

## Interface
- `MAX_HP`, 400: starting and maximum HP. Must be ≤ 400; the bar is 1 px per HP.
- `DMG_SHIFT`, 1: applied damage is `damage >> DMG_SHIFT`.
- `HIT_FRAMES`, 60: frames the hit flash lasts before the turn ends.
- `TIMEOUT_FRAMES`, 300: frames in the attack state without a press before the turn ends as a miss.
- `BAR_X0`, 120; `BAR_Y0`, 60; `BAR_H`, 10: HP bar origin and height.
- `CRIT_THRESH`, 190: raw damage at or above this value is critical (see Configuration).
- `clk`  in  1  pixel clock, shared with the VGA timing block.
- `rst_n`  in  1  asynchronous, active-low reset.
- `x`, `y`  in  10 each  current pixel coordinates.
- `state`  in  4  game state; 2 = attack turn.
- `spacePressed`  in  1  level from the attack stage, high while the space make-code is held.
- `damage`  in  10  raw damage (0..200), valid whenever `spacePressed`=1.
- `hp`  out  10  current HP. Reset value `MAX_HP`.
- `hpBarOn`  out  1  pixel lies in the filled part of the bar. Reset 0.
- `hpBarEmptyOn`  out  1  pixel lies in the depleted part of the bar. Reset 0.
- `hitFlash`  out  1  high during the HIT state. Reset 0.
- `attackDone`  out  1  one-cycle pulse at the end of the turn. Reset 0.
- `missed`  out  1  qualifies `attackDone`; 1 means the turn timed out. Reset 0.
- `enemyDead`  out  1  sticky until reset. Reset 0.

## Operation
- Frame tick: internal one-cycle pulse when `x==639 && y==479`.
- Press edge: `spacePressed` high while it was low on the previous cycle. Held keys never produce a second hit.
- FSM states: IDLE, ARMED, APPLY, HIT, DONE, DEAD.
  - IDLE → ARMED when `state==2` and `enemyDead`=0. Entering ARMED clears the frame counter.
  - ARMED, press edge: latch `damage`, go to APPLY.
  - ARMED, `state!=2`: go to IDLE. No damage is applied and no `attackDone` pulse is issued.
  - ARMED, frame counter reaches `TIMEOUT_FRAMES`: go to DONE with `missed`=1.
  - APPLY (one cycle): compute `hp <= (hp > d) ? hp - d : 0`, where `d = latched >> DMG_SHIFT`. Go to HIT with the frame counter cleared.
  - HIT: `hitFlash`=1. Ignores `state` and further presses. After `HIT_FRAMES` ticks go to DONE.
  - DONE (one cycle): pulse `attackDone`. Go to DEAD if `hp==0`, otherwise wait in IDLE until `state!=2`. This re-arm guard stops a repeat turn inside the same state.
  - DEAD: `enemyDead`=1. All inputs ignored. Exit only by reset.
- Zero damage (press at a bar edge) is a valid hit: HP is unchanged, HIT still runs, `missed`=0.
- `missed` holds its value until the next entry into ARMED.
- Bar pixels, for `BAR_Y0 ≤ y < BAR_Y0+BAR_H`:
  - `hpBarOn` when `BAR_X0 ≤ x < BAR_X0+hp`.
  - `hpBarEmptyOn` when `BAR_X0+hp ≤ x < BAR_X0+MAX_HP`.
  - Both flags are drawn in all states, including DEAD.
- Arithmetic: all operands are 10-bit unsigned. The subtraction never wraps.

## Timing
- Pixel flags are registered: they are valid one cycle after the matching `x`,`y`.
- `hp` updates on the cycle after APPLY, which is 2 cycles after the press edge.
- `attackDone` pulses exactly `HIT_FRAMES` frame ticks plus 1 cycle after APPLY.
- A press edge and a timeout on the same cycle: the press wins.
- Asserting `rst_n` mid-turn immediately restores every output to its reset value and the FSM to IDLE.

## Configuration
- `ENEMY_HP_CRIT_EN` defined: raw `damage ≥ CRIT_THRESH` applies `2*d`, still saturating at 0, and `hitFlash` toggles every 4 frames during HIT.
- `ENEMY_HP_CRIT_EN` undefined: no critical path, and `hitFlash` is a steady level.

## Structure
- Shared package `game_pkg`:
  - game state encodings (`ST_ATTACK`=2, etc.);
  - screen constants (639/479);
  - default `MAX_HP`.
- One sub-module, `frame_counter`: takes the frame tick plus a synchronous clear and provides the count. It is reused by both the timeout and HIT timing.

## Test plan
- Reset, then `state`=2; press with `damage`=200 → 2 cycles later `hp`=300; `attackDone` pulses after 60 frames with `missed`=0.
- Hold `spacePressed` high for 3 frames with `damage`=100 → only one hit applied; `hp`=350.
- `hp`=30, press with `damage`=120 → `hp`=0; after the pulse `enemyDead`=1; further presses leave `hp`=0.
- `state`=2 with no press for 300 frames → `attackDone` pulse with `missed`=1; `hp` unchanged.
- `hp`=250 at `y`=65: `x`=369 → `hpBarOn`=1; `x`=370 → `hpBarEmptyOn`=1; `x`=520 → both 0.
- `rst_n` low during HIT → `hitFlash`=0 and `hp`=400 immediately. With `ENEMY_HP_CRIT_EN`, a press with `damage`=195 → `hp`=206.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game constants: state encodings, screen limits, default HP and the enemy FSM states.
package game_pkg;

  localparam logic [3:0] ST_TITLE  = 4'd0;
  localparam logic [3:0] ST_MENU   = 4'd1;
  localparam logic [3:0] ST_ATTACK = 4'd2;
  localparam logic [3:0] ST_DEFEND = 4'd3;
  localparam logic [3:0] ST_OVER   = 4'd4;

  localparam logic [9:0] SCR_X_LAST = 10'd639;
  localparam logic [9:0] SCR_Y_LAST = 10'd479;

  localparam int unsigned DEF_MAX_HP = 400;
  localparam int          HP_W       = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_APPLY,
    S_HIT,
    S_DONE,
    S_DEAD
  } ehp_state_e;

endpackage

// File: rtl/enemy_hp_if.sv
// Attack-turn handshake between the game FSM / attack stage (master) and the enemy HP tracker (slave).
interface enemy_hp_if;
  import game_pkg::*;

  logic [3:0]      state;
  logic            spacePressed;
  logic [HP_W-1:0] damage;
  logic [HP_W-1:0] hp;
  logic            hitFlash;
  logic            attackDone;
  logic            missed;
  logic            enemyDead;

  modport master (
    output state, spacePressed, damage,
    input  hp, hitFlash, attackDone, missed, enemyDead
  );

  modport slave (
    input  state, spacePressed, damage,
    output hp, hitFlash, attackDone, missed, enemyDead
  );

endinterface

// File: rtl/enemy_hp_frame_counter.sv
// Frame counter shared by the attack timeout and the hit-flash timing; clear has priority over tick.
module frame_counter #(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (tick)
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/enemy_hp.sv
// Enemy HP tracker: one saturating hit per attack turn, hit/turn timing and HP bar pixels.
// Build option ENEMY_HP_CRIT_EN enables critical hits (double damage) and a blinking hit flash.
module enemy_hp
  import game_pkg::*;
#(
  parameter int unsigned MAX_HP         = DEF_MAX_HP,
  parameter int unsigned DMG_SHIFT      = 1,
  parameter int unsigned HIT_FRAMES     = 60,
  parameter int unsigned TIMEOUT_FRAMES = 300,
  parameter int unsigned BAR_X0         = 120,
  parameter int unsigned BAR_Y0         = 60,
  parameter int unsigned BAR_H          = 10,
  parameter int unsigned CRIT_THRESH    = 190
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [HP_W-1:0]  x,
  input  logic [HP_W-1:0]  y,
  enemy_hp_if.slave        bus,
  output logic             hpBarOn,
  output logic             hpBarEmptyOn
);

  localparam int CNT_W = 10;

  ehp_state_e      fsm_q;
  logic [HP_W-1:0] hp_q, dmg_q;
  logic            sp_prev_q, rearm_block_q;
  logic            hit_flash_q, attack_done_q, missed_q, enemy_dead_q;
  logic            frame_tick, press_edge, in_attack, cnt_clr;
  logic            timeout_hit, hit_over;
  logic [CNT_W-1:0] frame_cnt;
  logic [HP_W:0]   hit_amt;
  logic [HP_W:0]   x_e, y_e, fill_end;
  logic            row_hit;
  logic            bar_on_d, bar_on_q, bar_empty_d, bar_empty_q;
`ifdef ENEMY_HP_CRIT_EN
  logic            crit_q;
`endif

  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] a, input logic [HP_W:0] b);
    return ({1'b0, a} > b) ? (a - b[HP_W-1:0]) : '0;
  endfunction

  assign frame_tick  = (x == SCR_X_LAST) && (y == SCR_Y_LAST);
  assign press_edge  = bus.spacePressed && !sp_prev_q;
  assign in_attack   = (bus.state == ST_ATTACK);
  assign cnt_clr     = (fsm_q == S_IDLE) || (fsm_q == S_APPLY);
  assign timeout_hit = frame_tick && (frame_cnt == CNT_W'(TIMEOUT_FRAMES - 1));
  assign hit_over    = frame_tick && (frame_cnt == CNT_W'(HIT_FRAMES - 1));

  frame_counter #(.CNT_W(CNT_W)) u_frame_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (frame_tick),
    .clr   (cnt_clr),
    .count (frame_cnt)
  );

  always_comb begin
    hit_amt = {1'b0, dmg_q >> DMG_SHIFT};
`ifdef ENEMY_HP_CRIT_EN
    if (crit_q)
      hit_amt = {dmg_q >> DMG_SHIFT, 1'b0};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q         <= S_IDLE;
      hp_q          <= HP_W'(MAX_HP);
      dmg_q         <= '0;
      sp_prev_q     <= 1'b0;
      rearm_block_q <= 1'b0;
      hit_flash_q   <= 1'b0;
      attack_done_q <= 1'b0;
      missed_q      <= 1'b0;
      enemy_dead_q  <= 1'b0;
`ifdef ENEMY_HP_CRIT_EN
      crit_q        <= 1'b0;
`endif
    end else begin
      sp_prev_q     <= bus.spacePressed;
      attack_done_q <= 1'b0;
      unique case (fsm_q)
        S_IDLE: begin
          // Leaving the attack state re-enables arming, so one turn per attack state.
          if (!in_attack)
            rearm_block_q <= 1'b0;
          else if (!rearm_block_q && !enemy_dead_q) begin
            fsm_q    <= S_ARMED;
            missed_q <= 1'b0;
          end
        end
        S_ARMED: begin
          if (press_edge) begin
            dmg_q <= bus.damage;
`ifdef ENEMY_HP_CRIT_EN
            crit_q <= (bus.damage >= HP_W'(CRIT_THRESH));
`endif
            fsm_q <= S_APPLY;
          end else if (!in_attack) begin
            fsm_q <= S_IDLE;
          end else if (timeout_hit) begin
            fsm_q         <= S_DONE;
            missed_q      <= 1'b1;
            attack_done_q <= 1'b1;
            rearm_block_q <= 1'b1;
          end
        end
        S_APPLY: begin
          hp_q        <= sat_sub(hp_q, hit_amt);
          hit_flash_q <= 1'b1;
          fsm_q       <= S_HIT;
        end
        S_HIT: begin
          if (hit_over) begin
            fsm_q         <= S_DONE;
            hit_flash_q   <= 1'b0;
            attack_done_q <= 1'b1;
            rearm_block_q <= 1'b1;
          end
`ifdef ENEMY_HP_CRIT_EN
          else if (frame_tick && (frame_cnt[1:0] == 2'b11))
            hit_flash_q <= ~hit_flash_q;
`endif
        end
        S_DONE: begin
          if (hp_q == '0) begin
            fsm_q        <= S_DEAD;
            enemy_dead_q <= 1'b1;
          end else begin
            fsm_q <= S_IDLE;
          end
        end
        S_DEAD: fsm_q <= S_DEAD;
        default: fsm_q <= S_IDLE;
      endcase
    end
  end

  // Bar geometry in 11 bits so BAR_X0 + hp never wraps.
  always_comb begin
    x_e         = {1'b0, x};
    y_e         = {1'b0, y};
    row_hit     = (y_e >= (HP_W+1)'(BAR_Y0)) && (y_e < (HP_W+1)'(BAR_Y0 + BAR_H));
    fill_end    = (HP_W+1)'(BAR_X0) + {1'b0, hp_q};
    bar_on_d    = row_hit && (x_e >= (HP_W+1)'(BAR_X0)) && (x_e < fill_end);
    bar_empty_d = row_hit && (x_e >= fill_end) && (x_e < (HP_W+1)'(BAR_X0 + MAX_HP));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bar_on_q    <= 1'b0;
      bar_empty_q <= 1'b0;
    end else begin
      bar_on_q    <= bar_on_d;
      bar_empty_q <= bar_empty_d;
    end
  end

  assign hpBarOn        = bar_on_q;
  assign hpBarEmptyOn   = bar_empty_q;
  assign bus.hp         = hp_q;
  assign bus.hitFlash   = hit_flash_q;
  assign bus.attackDone = attack_done_q;
  assign bus.missed     = missed_q;
  assign bus.enemyDead  = enemy_dead_q;

endmodule

// File: tb/tb_enemy_hp.sv
// Directed bench for enemy_hp: pixel vector table plus hand-written attack-turn sequences.
module tb_enemy_hp;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] x, y;
  logic       hpBarOn, hpBarEmptyOn;

  enemy_hp_if bus();

  enemy_hp dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .x            (x),
    .y            (y),
    .bus          (bus),
    .hpBarOn      (hpBarOn),
    .hpBarEmptyOn (hpBarEmptyOn)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       on;
    logic       empty;
  } pix_vec_t;

  pix_vec_t pv[10];
  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp)
      passed++;
    else
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic arm();
    bus.state = 4'd0;
    step();
    bus.state = 4'd2;
    step();
  endtask

  task automatic press(input string name, input int dmg, input int hp_before, input int hp_after);
    bus.damage       = 10'(dmg);
    bus.spacePressed = 1'b1;
    step();
    check({name, " hp+1"}, 32'(bus.hp), 32'(hp_before));
    step();
    check({name, " hp+2"}, 32'(bus.hp), 32'(hp_after));
  endtask

  task automatic wait_done(input string name, input int exp_ticks, input logic exp_missed);
    int ticks = 0;
    bit seen = 1'b0;
    bit last_tick = 1'b0;
    for (int i = 0; i < 1500 && !seen; i++) begin
      last_tick = (i % 3 == 2);
      x = last_tick ? 10'd639 : 10'd0;
      y = last_tick ? 10'd479 : 10'd0;
      step();
      if (last_tick) ticks++;
      if (bus.attackDone === 1'b1) seen = 1'b1;
    end
    x = 10'd0;
    y = 10'd0;
    check({name, " pulse seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({name, " frames"}, 32'(ticks), 32'(exp_ticks));
      check({name, " on tick"}, 32'(last_tick), 32'd1);
      check({name, " missed"}, 32'(bus.missed), 32'(exp_missed));
      step();
      check({name, " pulse width"}, 32'(bus.attackDone), 32'd0);
    end
  endtask

  task automatic do_turn(input string name, input int dmg, input int hp_before, input int hp_after);
    arm();
    press(name, dmg, hp_before, hp_after);
    bus.spacePressed = 1'b0;
    wait_done(name, 60, 1'b0);
  endtask

  initial begin
    pv[0] = '{10'd369, 10'd65, 1'b1, 1'b0};
    pv[1] = '{10'd370, 10'd65, 1'b0, 1'b1};
    pv[2] = '{10'd520, 10'd65, 1'b0, 1'b0};
    pv[3] = '{10'd519, 10'd65, 1'b0, 1'b1};
    pv[4] = '{10'd120, 10'd60, 1'b1, 1'b0};
    pv[5] = '{10'd119, 10'd65, 1'b0, 1'b0};
    pv[6] = '{10'd200, 10'd59, 1'b0, 1'b0};
    pv[7] = '{10'd200, 10'd69, 1'b1, 1'b0};
    pv[8] = '{10'd200, 10'd70, 1'b0, 1'b0};
    pv[9] = '{10'd120, 10'd69, 1'b1, 1'b0};

    rst_n            = 1'b0;
    x                = 10'd0;
    y                = 10'd0;
    bus.state        = 4'd0;
    bus.spacePressed = 1'b0;
    bus.damage       = 10'd0;
    step();
    step();
    check("reset hp", 32'(bus.hp), 32'd400);
    check("reset hitFlash", 32'(bus.hitFlash), 32'd0);
    check("reset attackDone", 32'(bus.attackDone), 32'd0);
    check("reset missed", 32'(bus.missed), 32'd0);
    check("reset enemyDead", 32'(bus.enemyDead), 32'd0);
    check("reset hpBarOn", 32'(hpBarOn), 32'd0);
    check("reset hpBarEmptyOn", 32'(hpBarEmptyOn), 32'd0);
    rst_n = 1'b1;
    step();

    // Full hit: 200 raw -> 100 applied.
    do_turn("hit200", 200, 400, 300);

    // Key held through the whole turn and across the re-arm: exactly one hit.
    arm();
    press("held", 100, 300, 250);
    wait_done("held", 60, 1'b0);
    arm();
    repeat (6) step();
    check("held no rehit", 32'(bus.hp), 32'd250);
    bus.state = 4'd0;
    step();
    check("abort no pulse", 32'(bus.attackDone), 32'd0);
    bus.spacePressed = 1'b0;
    step();
    check("abort hp", 32'(bus.hp), 32'd250);

    // Bar pixels at hp = 250.
    for (int i = 0; i < 10; i++) begin
      x = pv[i].x;
      y = pv[i].y;
      step();
      check($sformatf("pix%0d on", i), 32'(hpBarOn), 32'(pv[i].on));
      check($sformatf("pix%0d empty", i), 32'(hpBarEmptyOn), 32'(pv[i].empty));
    end
    x = 10'd0;
    y = 10'd0;

    // Timeout as a miss.
    arm();
    wait_done("timeout", 300, 1'b1);
    check("timeout hp", 32'(bus.hp), 32'd250);
    check("missed holds", 32'(bus.missed), 32'd1);
    arm();
    check("missed cleared on arm", 32'(bus.missed), 32'd0);

    // Walk hp down to 30, including a zero-damage hit, then kill.
    do_turn("hit200b", 200, 250, 150);
    do_turn("hit200c", 200, 150, 50);
    do_turn("zero dmg", 1, 50, 50);
    do_turn("hit40", 40, 50, 30);
    do_turn("kill", 120, 30, 0);
    check("enemyDead", 32'(bus.enemyDead), 32'd1);
    arm();
    bus.damage       = 10'd200;
    bus.spacePressed = 1'b1;
    repeat (5) step();
    check("dead hp", 32'(bus.hp), 32'd0);
    check("dead no pulse", 32'(bus.attackDone), 32'd0);
    check("dead hitFlash", 32'(bus.hitFlash), 32'd0);
    bus.spacePressed = 1'b0;
    x = 10'd120;
    y = 10'd65;
    step();
    check("dead bar on", 32'(hpBarOn), 32'd0);
    check("dead bar empty", 32'(hpBarEmptyOn), 32'd1);
    x = 10'd0;
    y = 10'd0;

    // Reset clears the sticky dead flag.
    rst_n = 1'b0;
    #1;
    check("rst dead clr", 32'(bus.enemyDead), 32'd0);
    check("rst hp", 32'(bus.hp), 32'd400);
    step();
    rst_n = 1'b1;
    step();

    // Reset asserted mid-HIT acts immediately.
    arm();
    press("prehit", 200, 400, 300);
    bus.spacePressed = 1'b0;
    repeat (10) step();
    check("in hit flash", 32'(bus.hitFlash), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async hitFlash", 32'(bus.hitFlash), 32'd0);
    check("async hp", 32'(bus.hp), 32'd400);
    step();
    rst_n = 1'b1;
    step();

`ifdef ENEMY_HP_CRIT_EN
    do_turn("crit195", 195, 400, 206);
`else
    do_turn("plain195", 195, 400, 303);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
